// File: rtl/shift_exec_stage_if.sv
// Handshake bundle for the shift execute stage: an upstream operand channel
// and a downstream result channel, each with its own valid/ready pair.
interface shift_exec_stage_if;
  // Upstream operand channel
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs;
  logic [31:0] in_rt;
  logic [4:0]  in_rd;

  // Downstream result channel
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_illegal;

  // Producer of operands / consumer of results
  modport master (
    output in_valid, in_instr, in_rs, in_rt, in_rd, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_illegal
  );

  // The execute stage itself
  modport slave (
    input  in_valid, in_instr, in_rs, in_rt, in_rd, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_illegal
  );
endinterface

// File: rtl/shift_exec_stage.sv
// Two-register execute stage for the MIPS shift group.
// Stage A holds the accepted operands; decode, the shift core and the
// arithmetic fill are combinational from stage A; stage B holds the result
// toward writeback. Full throughput, two cycles from accept to out_valid.

// Rotate/logical shift core.
//   sh_c 00: logical right, 01: logical left, 10: rotate right.
module shift_core (
  input  logic [31:0] data_i,
  input  logic [4:0]  amt_i,
  input  logic [1:0]  sh_c_i,
  output logic [31:0] result_o
);
  logic [63:0] dbl_s;

  // Doubling the word turns a rotate into a plain right shift of 64 bits
  always_comb begin
    dbl_s    = {data_i, data_i} >> amt_i;
    result_o = data_i;
    case (sh_c_i)
      2'b00:   result_o = data_i >> amt_i;
      2'b01:   result_o = data_i << amt_i;
      2'b10:   result_o = dbl_s[31:0];
      default: result_o = data_i;
    endcase
  end
endmodule

module shift_exec_stage #(
  parameter bit SRA_EN = 1'b1,
  parameter bit ROT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  shift_exec_stage_if.slave bus
);

  // Stage A: only the instruction fields the shift group actually looks at
  // are kept (funct, sa, R bit) plus the low five bits of rs.
  logic        a_valid_q;
  logic [5:0]  a_funct_q;
  logic [4:0]  a_sa_q;
  logic        a_rbit_q;
  logic [4:0]  a_rsamt_q;
  logic [31:0] a_rt_q;
  logic [4:0]  a_rd_q;

  // Stage B (visible outputs)
  logic        out_valid_q;
  logic [31:0] out_result_q;
  logic [4:0]  out_rd_q;
  logic        out_illegal_q;

  // Decode / datapath
  logic [1:0]  sh_c_s;
  logic [4:0]  amt_s;
  logic        fill_s;
  logic        illegal_s;
  logic [31:0] core_res_s;
  logic [31:0] fill_mask_s;
  logic [31:0] out_result_d;

  // Handshake
  logic        in_ready_s;
  logic        a_take_s;
  logic        b_load_s;

  // A can take a new op when empty, or when B is free or draining this cycle,
  // which lets A's current op move on in the same edge.
  assign in_ready_s = !a_valid_q || !out_valid_q || bus.out_ready;
  assign a_take_s   = bus.in_valid && in_ready_s && !flush;
  assign b_load_s   = a_valid_q && (!out_valid_q || bus.out_ready);

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = out_result_q;
  assign bus.out_rd      = out_rd_q;
  assign bus.out_illegal = out_illegal_q;

  // Stage A occupancy: flush wins, then accept, then drain into B
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_q <= 1'b0;
    end else if (flush) begin
      a_valid_q <= 1'b0;
    end else if (a_take_s) begin
      a_valid_q <= 1'b1;
    end else if (b_load_s) begin
      a_valid_q <= 1'b0;
    end else begin
      a_valid_q <= a_valid_q;
    end
  end

  // Stage A operand capture; payload only matters while a_valid_q is set
  always_ff @(posedge clk) begin
    if (a_take_s) begin
      a_funct_q <= bus.in_instr[5:0];
      a_sa_q    <= bus.in_instr[10:6];
      a_rbit_q  <= bus.in_instr[21];
      a_rsamt_q <= bus.in_rs[4:0];
      a_rt_q    <= bus.in_rt;
      a_rd_q    <= bus.in_rd;
    end else begin
      a_funct_q <= a_funct_q;
      a_sa_q    <= a_sa_q;
      a_rbit_q  <= a_rbit_q;
      a_rsamt_q <= a_rsamt_q;
      a_rt_q    <= a_rt_q;
      a_rd_q    <= a_rd_q;
    end
  end

  // Decode funct into shift control, amount source and fill/illegal flags.
  // ROTRV is distinguished from SRLV by instr[6], i.e. the low bit of sa.
  always_comb begin
    sh_c_s    = 2'b00;
    amt_s     = a_sa_q;
    fill_s    = 1'b0;
    illegal_s = 1'b0;
    case (a_funct_q)
      6'h00: begin
        sh_c_s = 2'b01;
        amt_s  = a_sa_q;
      end
      6'h02: begin
        amt_s = a_sa_q;
        if (ROT_EN && a_rbit_q) begin
          sh_c_s = 2'b10;
        end else begin
          sh_c_s = 2'b00;
        end
      end
      6'h03: begin
        amt_s = a_sa_q;
        if (SRA_EN) begin
          sh_c_s = 2'b00;
          fill_s = 1'b1;
        end else begin
          illegal_s = 1'b1;
        end
      end
      6'h04: begin
        sh_c_s = 2'b01;
        amt_s  = a_rsamt_q;
      end
      6'h06: begin
        amt_s = a_rsamt_q;
        if (ROT_EN && a_sa_q[0]) begin
          sh_c_s = 2'b10;
        end else begin
          sh_c_s = 2'b00;
        end
      end
      6'h07: begin
        amt_s = a_rsamt_q;
        if (SRA_EN) begin
          sh_c_s = 2'b00;
          fill_s = 1'b1;
        end else begin
          illegal_s = 1'b1;
        end
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
  end

  shift_core u_core (
    .data_i   (a_rt_q),
    .amt_i    (amt_s),
    .sh_c_i   (sh_c_s),
    .result_o (core_res_s)
  );

  // Arithmetic fill: set the top amt bits when shifting a negative value.
  // amt=0 yields an all-zero mask, so the value passes through unchanged.
  always_comb begin
    fill_mask_s  = 32'h0000_0000;
    out_result_d = 32'h0000_0000;
    if (fill_s && a_rt_q[31]) begin
      fill_mask_s = ~(32'hFFFF_FFFF >> amt_s);
    end else begin
      fill_mask_s = 32'h0000_0000;
    end
    if (illegal_s) begin
      out_result_d = 32'h0000_0000;
    end else begin
      out_result_d = core_res_s | fill_mask_s;
    end
  end

  // Stage B valid: flush wins over a downstream accept
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (b_load_s) begin
      out_valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_q;
    end
  end

  // Stage B payload: held constant while stalled, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      out_result_q  <= 32'h0000_0000;
      out_rd_q      <= 5'd0;
      out_illegal_q <= 1'b0;
    end else if (b_load_s && !flush) begin
      out_result_q  <= out_result_d;
      out_rd_q      <= a_rd_q;
      out_illegal_q <= illegal_s;
    end else begin
      out_result_q  <= out_result_q;
      out_rd_q      <= out_rd_q;
      out_illegal_q <= out_illegal_q;
    end
  end

endmodule
